tick_timer_scheduler: RTL and testbench

- Shares one tick-driven down-counter between NREQ requesters. Typical requesters: lockout delay, display blink and keypad timeout.
- Consumes the single-cycle TICK pulse produced by the clock divider.
- Grants requesters round-robin, times the granted duration in ticks, and signals completion with a one-cycle DONE pulse.
- Sits between the clock divider and the lock control FSMs.

---
 rtl/tick_sched_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/tick_timer_scheduler.sv | 133 +++++++++++++
 tb/tb_tick_timer_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types and helpers for the tick-driven timer scheduler.
// Holds the FSM state encoding and the round-robin search used by the arbiter.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int MAX_NREQ = 8;
  localparam int PTR_W    = 3;

  // First set request at or above ptr, wrapping at nreq; 0 when nothing is set.
  function automatic int rr_first_idx(input logic [MAX_NREQ-1:0] req,
                                      input int ptr,
                                      input int nreq);
    int   idx;
    int   j;
    logic found;
    idx   = 0;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      j = (ptr + k) % nreq;
      if ((k < nreq) && !found && req[j]) begin
        idx   = j;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant of the first request
// found searching upward from ptr_i with wrap-around.
module rr_arbiter
  import tick_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  logic [MAX_NREQ-1:0] req_ext;

  // Search the widened request vector and build the one-hot grant.
  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req_i;
    idx_o               = IDXW'(rr_first_idx(req_ext, int'(ptr_i), NREQ));
    valid_o             = |req_i;
    gnt_o               = '0;
    if (valid_o) begin
      gnt_o[idx_o] = 1'b1;
    end else begin
      gnt_o = '0;
    end
  end

endmodule

// File: rtl/tick_timer_scheduler.sv
// Shares one tick-driven down-counter between NREQ requesters, granting them
// round-robin and pulsing DONE to the owner when its duration expires.
module tick_timer_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDXW = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               TICK,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*DW-1:0] DURATION,
  output logic [NREQ-1:0]    GRANT,
  output logic [NREQ-1:0]    DONE,
  output logic               BUSY,
  output logic [DW-1:0]      REMAIN
);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic [DW-1:0]     remain_q, remain_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IDXW-1:0]   arb_idx;
  logic              arb_valid;
  logic [IDXW-1:0]   owner_inc;

  rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
    .req_i   (REQ),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign owner_inc = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + IDXW'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    done_d   = '0;
    busy_d   = busy_q;
    remain_d = remain_q;
    case (state_q)
      IDLE: begin
        // A TICK here is deliberately not counted; the duration loads unchanged.
        if (arb_valid) begin
          state_d  = RUN;
          owner_d  = arb_idx;
          grant_d  = arb_gnt;
          busy_d   = 1'b1;
          remain_d = DURATION[int'(arb_idx)*DW +: DW];
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Cancel outranks completion, so a drop on the final tick yields no DONE.
        if (!REQ[owner_q]) begin
          state_d  = IDLE;
          grant_d  = '0;
          busy_d   = 1'b0;
          remain_d = '0;
          ptr_d    = owner_inc;
        end else if (remain_q == '0) begin
          state_d  = FIN;
          done_d   = grant_q;
          grant_d  = '0;
          busy_d   = 1'b0;
        end else if (TICK && (remain_q == DW'(1))) begin
          state_d  = FIN;
          done_d   = grant_q;
          grant_d  = '0;
          busy_d   = 1'b0;
          remain_d = '0;
        end else if (TICK) begin
          remain_d = remain_q - DW'(1);
        end else begin
          state_d = RUN;
        end
      end
      FIN: begin
        state_d  = IDLE;
        ptr_d    = owner_inc;
        grant_d  = '0;
        busy_d   = 1'b0;
        remain_d = '0;
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        busy_d   = 1'b0;
        remain_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      remain_q <= remain_d;
    end
  end

  assign GRANT  = grant_q;
  assign DONE   = done_q;
  assign BUSY   = busy_q;
  assign REMAIN = remain_q;

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Self-checking bench for tick_timer_scheduler: hand-written vector table,
// hand sequences, and a reference-model scoreboard for random traffic.
module tb_tick_timer_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IDXW = 2;

  logic              CLK;
  logic              RST;
  logic              TICK;
  logic [NREQ-1:0]   REQ;
  logic [NREQ*DW-1:0] DURATION;
  logic [NREQ-1:0]   GRANT;
  logic [NREQ-1:0]   DONE;
  logic              BUSY;
  logic [DW-1:0]     REMAIN;

  tick_timer_scheduler #(.NREQ(NREQ), .DW(DW), .IDXW(IDXW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .TICK     (TICK),
    .REQ      (REQ),
    .DURATION (DURATION),
    .GRANT    (GRANT),
    .DONE     (DONE),
    .BUSY     (BUSY),
    .REMAIN   (REMAIN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] d;
    logic       b;
    logic [7:0] r;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        tick;
    logic [3:0]  req;
    logic [31:0] dur;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state: 0 idle, 1 run, 2 fin
  int   m_state = 0;
  int   m_owner = 0;
  int   m_ptr   = 0;
  int   m_rem   = 0;

  function automatic vec_t v(input logic rst, input logic tick, input logic [3:0] req,
                             input logic [31:0] dur, input logic [3:0] g,
                             input logic [3:0] d, input logic b, input logic [7:0] r);
    vec_t x;
    x.rst  = rst;
    x.tick = tick;
    x.req  = req;
    x.dur  = dur;
    x.e.g  = g;
    x.e.d  = d;
    x.e.b  = b;
    x.e.r  = r;
    return x;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if (GRANT !== e.g || DONE !== e.d || BUSY !== e.b || REMAIN !== e.r) begin
        n_errors++;
        $display("FAIL %s: got g=%b d=%b b=%b r=%0d want g=%b d=%b b=%b r=%0d",
                 tag, GRANT, DONE, BUSY, REMAIN, e.g, e.d, e.b, e.r);
      end
    end
    n_checks++;
    if ($countones(GRANT) > 1 || (GRANT & DONE) != 4'b0000) begin
      n_errors++;
      $display("FAIL %s invariant: got g=%b d=%b want onehot0 grant disjoint from done",
               tag, GRANT, DONE);
    end
  endtask

  task automatic drive(input logic rst, input logic tick, input logic [3:0] req,
                       input logic [31:0] dur, input exp_t e, input string tag);
    RST      = rst;
    TICK     = tick;
    REQ      = req;
    DURATION = dur;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    compare(tag);
  endtask

  task automatic model(input logic rst, input logic tick, input logic [3:0] req,
                       input logic [31:0] dur, output exp_t e);
    int  j;
    bit  found;
    if (rst) begin
      m_state = 0; m_owner = 0; m_ptr = 0; m_rem = 0;
    end else if (m_state == 0) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (!found && req[j]) begin
          found = 1; m_owner = j;
        end
      end
      if (found) begin
        m_state = 1;
        m_rem   = int'(dur[m_owner*8 +: 8]);
      end
    end else if (m_state == 1) begin
      if (!req[m_owner]) begin
        m_state = 0; m_rem = 0; m_ptr = (m_owner + 1) % 4;
      end else if (m_rem == 0) begin
        m_state = 2;
      end else if (tick && m_rem == 1) begin
        m_state = 2; m_rem = 0;
      end else if (tick) begin
        m_rem = m_rem - 1;
      end
    end else begin
      m_state = 0; m_rem = 0; m_ptr = (m_owner + 1) % 4;
    end
    e.g = (m_state == 1) ? 4'(1 << m_owner) : 4'b0000;
    e.d = (m_state == 2) ? 4'(1 << m_owner) : 4'b0000;
    e.b = (m_state == 1);
    e.r = (m_state == 1) ? 8'(m_rem) : 8'd0;
  endtask

  task automatic mstep(input logic rst, input logic tick, input logic [3:0] req,
                       input logic [31:0] dur, input string tag);
    exp_t e;
    model(rst, tick, req, dur, e);
    drive(rst, tick, req, dur, e, tag);
  endtask

  initial begin
    exp_t e;
    logic [3:0]  rreq;
    logic [31:0] rdur;
    logic        rtick;
    logic        rrst;
    RST = 1'b1; TICK = 1'b0; REQ = 4'b0000; DURATION = 32'h0;

    // reset state
    drive(1'b1, 1'b0, 4'b0000, 32'h0, exp_t'({4'b0000, 4'b0000, 1'b0, 8'd0}), "reset0");
    drive(1'b1, 1'b1, 4'b1111, 32'h0, exp_t'({4'b0000, 4'b0000, 1'b0, 8'd0}), "reset1");

    // single request, N=3, TICK every 10 cycles
    drive(1'b0, 1'b0, 4'b0001, 32'h3, exp_t'({4'b0001, 4'b0000, 1'b1, 8'd3}), "single_grant");
    for (int t = 1; t <= 3; t++) begin
      for (int c = 0; c < 9; c++)
        drive(1'b0, 1'b0, 4'b0001, 32'h3,
              exp_t'({4'b0001, 4'b0000, 1'b1, 8'(4 - t)}), "single_hold");
      if (t < 3)
        drive(1'b0, 1'b1, 4'b0001, 32'h3,
              exp_t'({4'b0001, 4'b0000, 1'b1, 8'(3 - t)}), "single_tick");
      else
        drive(1'b0, 1'b1, 4'b0001, 32'h3,
              exp_t'({4'b0000, 4'b0001, 1'b0, 8'd0}), "single_done");
    end
    drive(1'b0, 1'b0, 4'b0000, 32'h3, exp_t'({4'b0000, 4'b0000, 1'b0, 8'd0}), "single_idle");

    // round-robin, all durations 1
    tbl.push_back(v(1, 0, 4'b0000, 32'h01010101, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 0, 4'b1011, 32'h01010101, 4'b0001, 4'b0000, 1, 1));
    tbl.push_back(v(0, 1, 4'b1011, 32'h01010101, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(v(0, 0, 4'b1010, 32'h01010101, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 0, 4'b1010, 32'h01010101, 4'b0010, 4'b0000, 1, 1));
    tbl.push_back(v(0, 1, 4'b1010, 32'h01010101, 4'b0000, 4'b0010, 0, 0));
    tbl.push_back(v(0, 0, 4'b1000, 32'h01010101, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 0, 4'b1000, 32'h01010101, 4'b1000, 4'b0000, 1, 1));
    tbl.push_back(v(0, 1, 4'b1000, 32'h01010101, 4'b0000, 4'b1000, 0, 0));
    tbl.push_back(v(0, 0, 4'b0000, 32'h01010101, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 0, 4'b1001, 32'h01010101, 4'b0001, 4'b0000, 1, 1));
    tbl.push_back(v(0, 1, 4'b1001, 32'h01010101, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(v(0, 0, 4'b1000, 32'h01010101, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 0, 4'b1000, 32'h01010101, 4'b1000, 4'b0000, 1, 1));
    tbl.push_back(v(0, 1, 4'b1000, 32'h01010101, 4'b0000, 4'b1000, 0, 0));
    tbl.push_back(v(0, 0, 4'b0000, 32'h01010101, 4'b0000, 4'b0000, 0, 0));
    // cancel: owner 2 drops after 2 ticks, pending 3 follows
    tbl.push_back(v(0, 0, 4'b1100, 32'h02050000, 4'b0100, 4'b0000, 1, 5));
    tbl.push_back(v(0, 1, 4'b1100, 32'h02050000, 4'b0100, 4'b0000, 1, 4));
    tbl.push_back(v(0, 1, 4'b1100, 32'h02050000, 4'b0100, 4'b0000, 1, 3));
    tbl.push_back(v(0, 0, 4'b1000, 32'h02050000, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 0, 4'b1000, 32'h02050000, 4'b1000, 4'b0000, 1, 2));
    tbl.push_back(v(0, 1, 4'b1000, 32'h02050000, 4'b1000, 4'b0000, 1, 1));
    tbl.push_back(v(0, 1, 4'b1000, 32'h02050000, 4'b0000, 4'b1000, 0, 0));
    tbl.push_back(v(0, 0, 4'b0000, 32'h02050000, 4'b0000, 4'b0000, 0, 0));
    // zero duration and TICK in the arbitration cycle
    tbl.push_back(v(0, 1, 4'b0010, 32'h00030000, 4'b0010, 4'b0000, 1, 0));
    tbl.push_back(v(0, 0, 4'b0010, 32'h00030000, 4'b0000, 4'b0010, 0, 0));
    tbl.push_back(v(0, 0, 4'b0000, 32'h00030000, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 1, 4'b0100, 32'h00030000, 4'b0100, 4'b0000, 1, 3));
    tbl.push_back(v(0, 0, 4'b0100, 32'h00030000, 4'b0100, 4'b0000, 1, 3));
    tbl.push_back(v(0, 0, 4'b0000, 32'h00030000, 4'b0000, 4'b0000, 0, 0));
    // reset mid-run at REMAIN=4, then pointer back at 0
    tbl.push_back(v(0, 0, 4'b1000, 32'h06000003, 4'b1000, 4'b0000, 1, 6));
    tbl.push_back(v(0, 1, 4'b1000, 32'h06000003, 4'b1000, 4'b0000, 1, 5));
    tbl.push_back(v(0, 1, 4'b1000, 32'h06000003, 4'b1000, 4'b0000, 1, 4));
    tbl.push_back(v(1, 1, 4'b1000, 32'h06000003, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 0, 4'b1001, 32'h06000003, 4'b0001, 4'b0000, 1, 3));
    tbl.push_back(v(0, 0, 4'b1000, 32'h06000003, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 0, 4'b1000, 32'h06000003, 4'b1000, 4'b0000, 1, 6));
    tbl.push_back(v(0, 0, 4'b0000, 32'h06000003, 4'b0000, 4'b0000, 0, 0));
    // cancel and final tick in the same cycle
    tbl.push_back(v(0, 0, 4'b0001, 32'h00000001, 4'b0001, 4'b0000, 1, 1));
    tbl.push_back(v(0, 1, 4'b0000, 32'h00000001, 4'b0000, 4'b0000, 0, 0));
    tbl.push_back(v(0, 0, 4'b0000, 32'h00000001, 4'b0000, 4'b0000, 0, 0));

    for (int i = 0; i < tbl.size(); i++)
      drive(tbl[i].rst, tbl[i].tick, tbl[i].req, tbl[i].dur, tbl[i].e, $sformatf("vec%0d", i));

    // full-scale duration counts every tick down to DONE
    mstep(1'b1, 1'b0, 4'b0000, 32'h0, "max_rst");
    mstep(1'b0, 1'b0, 4'b0001, 32'h000000FF, "max_grant");
    for (int i = 0; i < 255; i++) begin
      mstep(1'b0, 1'b1, 4'b0001, 32'h000000FF, "max_tick");
      if (i == 254) begin
        n_checks++;
        if (DONE !== 4'b0001) begin
          n_errors++;
          $display("FAIL max_done: got %b want 0001", DONE);
        end
      end
    end
    mstep(1'b0, 1'b0, 4'b0000, 32'h000000FF, "max_idle");

    // random traffic against the reference model
    rreq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) rreq[b] = ~rreq[b];
      rtick = ($urandom_range(0, 2) == 0);
      rrst  = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < 4; b++)
        rdur[b*8 +: 8] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
      mstep(rrst, rtick, rreq, rdur, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
